// File: rtl/k005297_functimer_pkg.sv
// rtl/k005297_functimer_pkg.sv - shared types and constants for the bubble function timer
// Purpose: the FSM state enum, the coil quadrant boundaries, the default ROT20 phases
//          and a quadrant decode helper.
// Ports:   none (package).
package k005297_functimer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SPINUP   = 2'd1,
    ST_XFER     = 2'd2,
    ST_SPINDOWN = 2'd3
  } state_e;

  // First ROT20 index of each coil-drive quadrant
  localparam logic [4:0] QUAD_XP_START = 5'd0;
  localparam logic [4:0] QUAD_YP_START = 5'd5;
  localparam logic [4:0] QUAD_XN_START = 5'd10;
  localparam logic [4:0] QUAD_YN_START = 5'd15;

  localparam logic [4:0] ROT_LAST = 5'd19;

  localparam int GEN_PHASE_DEF  = 2;
  localparam int REPL_PHASE_DEF = 7;
  localparam int DET_PHASE_DEF  = 12;

  // One-hot coil vector {YN, XN, YP, XP} for a valid rotator index
  function automatic logic [3:0] quad_decode(input logic [4:0] idx);
    logic [4:0] rel;
    rel = idx - QUAD_XP_START;
    if (rel < QUAD_YP_START - QUAD_XP_START)      quad_decode = 4'b0001;
    else if (rel < QUAD_XN_START - QUAD_XP_START) quad_decode = 4'b0010;
    else if (rel < QUAD_YN_START - QUAD_XP_START) quad_decode = 4'b0100;
    else                                          quad_decode = 4'b1000;
  endfunction

endpackage

// File: rtl/k005297_rot20_decode.sv
// rtl/k005297_rot20_decode.sv - active-low one-hot 20-step rotator decoder
// Purpose: turns the ROT20 rotator into a 5-bit step index and a one-hot valid flag.
// Ports:   rot_n_i [19:0] active-low one-hot rotator
//          idx_o   [4:0]  position of the zero bit (meaningful only when valid_o)
//          valid_o        exactly one bit of rot_n_i is low
module k005297_rot20_decode (
  input  logic [19:0] rot_n_i,
  output logic [4:0]  idx_o,
  output logic        valid_o
);

  logic [4:0] zeros;

  always_comb begin
    idx_o = 5'd0;
    zeros = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (!rot_n_i[i]) begin
        idx_o = 5'(i);
        zeros = zeros + 5'd1;
      end
    end
    valid_o = (zeros == 5'd1);
  end

endmodule

// File: rtl/k005297_bubble_functimer.sv
// rtl/k005297_bubble_functimer.sv - bubble memory page-transfer function timer
// Purpose: sequences one READ or WRITE page transfer (spin-up fields, one bit per
//          transfer field, one spin-down field) on the 2 MHz enable and ROT20 rotator,
//          driving the coil quadrants and replicate/generate/swap pulses.
// Build option: K005297_FUNCTIMER_ROT20CHK_EN adds a sticky rotator one-hot error flag;
//               without it o_ROT20_ERR is tied to 0.
// Ports:   i_MCLK, i_MRST_n (async active-low), i_CLK2M_PCEN_n (active-low enable),
//          i_ROT20_n[19:0], i_SYS_RST_n (soft reset), i_SYS_RUN_FLAG, i_START,
//          i_CMD_WRITE, i_WDATA, i_DETECT;
//          o_XP/o_YP/o_XN/o_YN coils, o_REPLICATE/o_GENERATE/o_SWAP pulses,
//          o_BIT_REQ, o_RDATA, o_RBIT_STB, o_BITCNT, o_BUSY, o_DONE, o_ROT20_ERR.
module k005297_bubble_functimer
  import k005297_functimer_pkg::*;
#(
  parameter int PAGE_BITS     = 4096,
  parameter int SPINUP_FIELDS = 4,
  parameter int GEN_PHASE     = GEN_PHASE_DEF,
  parameter int REPL_PHASE    = REPL_PHASE_DEF,
  parameter int DET_PHASE     = DET_PHASE_DEF
) (
  input  logic                         i_MCLK,
  input  logic                         i_MRST_n,
  input  logic                         i_CLK2M_PCEN_n,
  input  logic [19:0]                  i_ROT20_n,
  input  logic                         i_SYS_RST_n,
  input  logic                         i_SYS_RUN_FLAG,
  input  logic                         i_START,
  input  logic                         i_CMD_WRITE,
  input  logic                         i_WDATA,
  input  logic                         i_DETECT,
  output logic                         o_XP,
  output logic                         o_YP,
  output logic                         o_XN,
  output logic                         o_YN,
  output logic                         o_REPLICATE,
  output logic                         o_GENERATE,
  output logic                         o_SWAP,
  output logic                         o_BIT_REQ,
  output logic                         o_RDATA,
  output logic                         o_RBIT_STB,
  output logic [$clog2(PAGE_BITS)-1:0] o_BITCNT,
  output logic                         o_BUSY,
  output logic                         o_DONE,
  output logic                         o_ROT20_ERR
);

  localparam int BW = $clog2(PAGE_BITS);
  // One extra bit so the counter can hold PAGE_BITS itself once the page is done
  localparam int CW = BW + 1;
  localparam int FW = (SPINUP_FIELDS < 2) ? 1 : $clog2(SPINUP_FIELDS + 1);

  logic [4:0] idx;
  logic       rot_valid;

  k005297_rot20_decode u_decode (
    .rot_n_i (i_ROT20_n),
    .idx_o   (idx),
    .valid_o (rot_valid)
  );

  state_e        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          rdata_q, rdata_d;
  logic [3:0]    coil_q, coil_d;   // {YN, XN, YP, XP}
  logic          repl_q, repl_d;
  logic          gen_q, gen_d;
  logic          swap_q, swap_d;
  logic          bitreq_q, bitreq_d;
  logic          rstb_q, rstb_d;
  logic          done_q, done_d;

  always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state_q  <= ST_IDLE;
      fcnt_q   <= '0;
      bitcnt_q <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= 1'b0;
      coil_q   <= '0;
      repl_q   <= 1'b0;
      gen_q    <= 1'b0;
      swap_q   <= 1'b0;
      bitreq_q <= 1'b0;
      rstb_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (!i_CLK2M_PCEN_n) begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      bitcnt_q <= bitcnt_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      rdata_q  <= rdata_d;
      coil_q   <= coil_d;
      repl_q   <= repl_d;
      gen_q    <= gen_d;
      swap_q   <= swap_d;
      bitreq_q <= bitreq_d;
      rstb_q   <= rstb_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    bitcnt_d = bitcnt_q;
    wr_d     = wr_q;
    busy_d   = busy_q;
    rdata_d  = rdata_q;
    coil_d   = '0;
    repl_d   = 1'b0;
    gen_d    = 1'b0;
    swap_d   = 1'b0;
    bitreq_d = 1'b0;
    rstb_d   = 1'b0;
    done_d   = 1'b0;

    if (!i_SYS_RST_n) begin
      // Abort: bit count is deliberately kept so software can see how far it got
      state_d = ST_IDLE;
      fcnt_d  = '0;
      busy_d  = 1'b0;
    end else if (rot_valid) begin
      // A broken rotator pattern freezes everything and silences coils/pulses
      if (state_q != ST_IDLE) coil_d = quad_decode(idx);

      case (state_q)
        ST_IDLE: begin
          if (i_START && i_SYS_RUN_FLAG && idx == ROT_LAST) begin
            wr_d     = i_CMD_WRITE;
            bitcnt_d = '0;
            fcnt_d   = '0;
            busy_d   = 1'b1;
            state_d  = (SPINUP_FIELDS == 0) ? ST_XFER : ST_SPINUP;
          end
        end

        ST_SPINUP: begin
          if (idx == ROT_LAST) begin
            if (fcnt_q == FW'(SPINUP_FIELDS - 1)) begin
              fcnt_d  = '0;
              state_d = ST_XFER;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
        end

        ST_XFER: begin
          if (idx == 5'd0) bitreq_d = 1'b1;
          if (!wr_q) begin
            if (idx == 5'(REPL_PHASE)) repl_d = 1'b1;
            if (idx == 5'(DET_PHASE)) begin
              rdata_d = i_DETECT;
              rstb_d  = 1'b1;
            end
          end else if (idx == 5'(GEN_PHASE)) begin
            gen_d = i_WDATA;
          end
          if (idx == ROT_LAST) begin
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == CW'(PAGE_BITS - 1)) state_d = ST_SPINDOWN;
          end
        end

        ST_SPINDOWN: begin
          if (wr_q && idx == 5'(GEN_PHASE)) swap_d = 1'b1;
          if (idx == ROT_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign o_XP        = coil_q[0];
  assign o_YP        = coil_q[1];
  assign o_XN        = coil_q[2];
  assign o_YN        = coil_q[3];
  assign o_REPLICATE = repl_q;
  assign o_GENERATE  = gen_q;
  assign o_SWAP      = swap_q;
  assign o_BIT_REQ   = bitreq_q;
  assign o_RDATA     = rdata_q;
  assign o_RBIT_STB  = rstb_q;
  assign o_BITCNT    = bitcnt_q[BW-1:0];
  assign o_BUSY      = busy_q;
  assign o_DONE      = done_q;

`ifdef K005297_FUNCTIMER_ROT20CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (!i_SYS_RST_n)    err_d = 1'b0;
    else if (!rot_valid) err_d = 1'b1;
  end

  always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n)            err_q <= 1'b0;
    else if (!i_CLK2M_PCEN_n) err_q <= err_d;
  end

  assign o_ROT20_ERR = err_q;
`else
  assign o_ROT20_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_k005297_bubble_functimer.sv
// tb/tb_k005297_bubble_functimer.sv - randomized scoreboard bench for the bubble function timer
module tb_k005297_bubble_functimer;

  localparam int PB  = 6;
  localparam int SF  = 2;
  localparam int GP  = 2;
  localparam int RP  = 7;
  localparam int DP  = 12;
  localparam int BW  = $clog2(PB);
  localparam int NEN = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcen_n = 1'b1;
  logic [19:0] rot_n = '1;
  logic        sys_rst_n = 1'b1;
  logic        run = 1'b0;
  logic        start = 1'b0;
  logic        cmd = 1'b0;
  logic        wdata = 1'b0;
  logic        detect = 1'b0;

  logic          xp, yp, xn, yn, repl, gen, swap, bitreq, rdata, rstb, busy, done, err;
  logic [BW-1:0] bitcnt;

  always #5 clk = ~clk;

  k005297_bubble_functimer #(
    .PAGE_BITS     (PB),
    .SPINUP_FIELDS (SF),
    .GEN_PHASE     (GP),
    .REPL_PHASE    (RP),
    .DET_PHASE     (DP)
  ) dut (
    .i_MCLK         (clk),
    .i_MRST_n       (rst_n),
    .i_CLK2M_PCEN_n (pcen_n),
    .i_ROT20_n      (rot_n),
    .i_SYS_RST_n    (sys_rst_n),
    .i_SYS_RUN_FLAG (run),
    .i_START        (start),
    .i_CMD_WRITE    (cmd),
    .i_WDATA        (wdata),
    .i_DETECT       (detect),
    .o_XP           (xp),
    .o_YP           (yp),
    .o_XN           (xn),
    .o_YN           (yn),
    .o_REPLICATE    (repl),
    .o_GENERATE     (gen),
    .o_SWAP         (swap),
    .o_BIT_REQ      (bitreq),
    .o_RDATA        (rdata),
    .o_RBIT_STB     (rstb),
    .o_BITCNT       (bitcnt),
    .o_BUSY         (busy),
    .o_DONE         (done),
    .o_ROT20_ERR    (err)
  );

  typedef struct packed {
    logic          xp, yp, xn, yn;
    logic          repl, gen, swap, bitreq, rdata, rstb;
    logic [BW-1:0] bitcnt;
    logic          busy, done, err;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_done = 0;
  int   n_start_seen = 0;

  // Reference model: a transfer is a count of whole fields since start
  bit m_active = 0, m_wr = 0, m_rdata = 0, m_err = 0;
  int m_field = 0, m_bitcnt = 0;
  int step = 0;

  function automatic out_t model_step(input bit valid, input int idx);
    out_t e;
    e = '0;
    if (!sys_rst_n) begin
      m_active = 0;
      m_err    = 0;
    end else if (!valid) begin
      m_err = 1;
    end else if (!m_active) begin
      if (start && run && idx == 19) begin
        m_active = 1;
        m_field  = 0;
        m_bitcnt = 0;
        m_wr     = cmd;
      end
    end else begin
      if (idx < 5)       e.xp = 1;
      else if (idx < 10) e.yp = 1;
      else if (idx < 15) e.xn = 1;
      else               e.yn = 1;
      if (m_field >= SF && m_field < SF + PB) begin
        if (idx == 0) e.bitreq = 1;
        if (!m_wr && idx == RP) e.repl = 1;
        if (!m_wr && idx == DP) begin
          m_rdata = detect;
          e.rstb  = 1;
        end
        if (m_wr && idx == GP) e.gen = wdata;
        if (idx == 19) m_bitcnt = m_field - SF + 1;
      end else if (m_field >= SF + PB) begin
        if (m_wr && idx == GP) e.swap = 1;
        if (idx == 19) begin
          e.done   = 1;
          m_active = 0;
        end
      end
      if (idx == 19) m_field++;
    end
    e.busy   = m_active;
    e.rdata  = m_rdata;
    e.bitcnt = BW'(m_bitcnt);
`ifdef K005297_FUNCTIMER_ROT20CHK_EN
    e.err = m_err;
`endif
    return e;
  endfunction

  function automatic out_t sample_dut();
    out_t a;
    a.xp = xp; a.yp = yp; a.xn = xn; a.yn = yn;
    a.repl = repl; a.gen = gen; a.swap = swap; a.bitreq = bitreq;
    a.rdata = rdata; a.rstb = rstb; a.bitcnt = bitcnt;
    a.busy = busy; a.done = done; a.err = err;
    return a;
  endfunction

  // Monitor: every enable edge produces one registered output set
  initial begin
    out_t a, e;
    bit   en;
    forever begin
      @(posedge clk);
      en = rst_n && !pcen_n;
      #1;
      if (en) begin
        a = sample_dut();
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_underflow: output at t=%0t with no expected entry", $time);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL enable_outputs t=%0t: actual=%h required=%h", $time, a, e);
          end
        end
        if (a.done) n_done++;
        if (a.busy) n_start_seen++;
      end
    end
  end

  // Driver: random inputs each cycle; model is advanced on enable cycles
  initial begin
    bit valid;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sample_dut() !== out_t'('0)) begin
      failures++;
      $display("FAIL reset_state: actual=%h required=%h", sample_dut(), out_t'('0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < NEN; ) begin
      @(negedge clk);
      pcen_n    = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 9) < 7);
      run       = ($urandom_range(0, 19) != 0);
      cmd       = 1'($urandom_range(0, 1));
      wdata     = 1'($urandom_range(0, 1));
      detect    = 1'($urandom_range(0, 1));
      sys_rst_n = ($urandom_range(0, 599) != 0);
      valid     = ($urandom_range(0, 149) != 0);
      if (valid)                         rot_n = ~(20'd1 << step);
      else if ($urandom_range(0, 1) == 1) rot_n = '1;
      else                               rot_n = ~((20'd1 << step) | (20'd1 << ((step + 7) % 20)));
      if (!pcen_n) begin
        exp_q.push_back(model_step(valid, step));
        if (valid) step = (step + 1) % 20;
        n++;
      end
    end

    @(negedge clk);
    pcen_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d entries left required=0", exp_q.size());
    end
    checks++;
    if (n_done == 0) begin
      failures++;
      $display("FAIL done_activity: actual=%0d done pulses required=>0", n_done);
    end
    checks++;
    if (n_start_seen == 0) begin
      failures++;
      $display("FAIL busy_activity: actual=%0d busy enables required=>0", n_start_seen);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
